// File: rtl/i2c_master_write_ctrl.sv
// Single-master I2C write sequencer: START, address+W, ACK check, N data bytes, STOP.
// Each SCL bit is four quarters of QTR_CYC clocks; all pad controls are registered.
module i2c_master_write_ctrl #(
   parameter int unsigned QTR_CYC = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [6:0] addr,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       nack,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       sda_i
);

   localparam int unsigned QCW = (QTR_CYC > 1) ? $clog2(QTR_CYC) : 1;
   localparam logic [QCW-1:0] QCNT_MAX = QCW'(QTR_CYC - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_START,
      S_ADDR,
      S_ADDR_ACK,
      S_WAIT_DATA,
      S_DATA,
      S_DATA_ACK,
      S_STOP,
      S_DONE
   } state_e;

   state_e         state_q, state_d;
   logic [QCW-1:0] qcnt_q, qcnt_d;
   logic [1:0]     qidx_q, qidx_d;
   logic [2:0]     bcnt_q, bcnt_d;
   logic [7:0]     shreg_q, shreg_d;
   logic [6:0]     addr_q, addr_d;
   logic           last_q, last_d;
   logic           ack_q, ack_d;
   logic           nack_q, nack_d;
   logic           scl_oe_q, scl_oe_d;
   logic           sda_oe_q, sda_oe_d;
   logic           tx_ready_q, tx_ready_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic           timed;
   logic           qtr_end;
   logic           bit_end;

   // Quarter/bit tick decode; the timebase only runs in states that shape SCL.
   always_comb begin
      timed   = (state_q == S_START) || (state_q == S_ADDR) || (state_q == S_ADDR_ACK) ||
                (state_q == S_DATA) || (state_q == S_DATA_ACK) || (state_q == S_STOP);
      qtr_end = timed && (qcnt_q == QCNT_MAX);
      bit_end = qtr_end && (qidx_q == 2'd3);
   end

   always_comb begin
      state_d = state_q;
      qcnt_d  = qcnt_q;
      qidx_d  = qidx_q;
      bcnt_d  = bcnt_q;
      shreg_d = shreg_q;
      addr_d  = addr_q;
      last_d  = last_q;
      ack_d   = ack_q;
      nack_d  = nack_q;

      if (timed) begin
         if (qtr_end) begin
            qcnt_d = '0;
            qidx_d = qidx_q + 2'd1;
         end else begin
            qcnt_d = qcnt_q + QCW'(1);
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_START;
               addr_d  = addr;
               nack_d  = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_ADDR;
               shreg_d = {addr_q, 1'b0};
            end
         end
         S_ADDR, S_DATA: begin
            if (bit_end) begin
               if (bcnt_q == 3'd0) begin
                  state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
               end else begin
                  bcnt_d  = bcnt_q - 3'd1;
                  shreg_d = {shreg_q[6:0], 1'b0};
               end
            end
         end
         S_ADDR_ACK, S_DATA_ACK: begin
            // Target response is captured at the end of the SCL-high Q2 and acted on after Q3.
            if (qtr_end && (qidx_q == 2'd2)) begin
               ack_d = sda_i;
            end
            if (bit_end) begin
               if (ack_q) begin
                  state_d = S_STOP;
                  nack_d  = 1'b1;
               end else if ((state_q == S_ADDR_ACK) || !last_q) begin
                  state_d = S_WAIT_DATA;
               end else begin
                  state_d = S_STOP;
               end
            end
         end
         S_WAIT_DATA: begin
            if (tx_valid && tx_ready_q) begin
               state_d = S_DATA;
               shreg_d = tx_data;
               last_d  = tx_last;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d != state_q) begin
         qcnt_d = '0;
         qidx_d = '0;
         bcnt_d = 3'd7;
      end
   end

   // Pad and handshake outputs decoded from next-state values so they register in step with state.
   always_comb begin
      scl_oe_d   = 1'b0;
      sda_oe_d   = 1'b0;
      tx_ready_d = (state_d == S_WAIT_DATA);
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);

      unique case (state_d)
         S_START: begin
            sda_oe_d = qidx_d[1];
         end
         S_ADDR, S_DATA: begin
            scl_oe_d = ~qidx_d[1];
            sda_oe_d = ~shreg_d[7];
         end
         S_ADDR_ACK, S_DATA_ACK: begin
            scl_oe_d = ~qidx_d[1];
         end
         S_WAIT_DATA: begin
            scl_oe_d = 1'b1;
         end
         S_STOP: begin
            scl_oe_d = ~qidx_d[1];
            sda_oe_d = (qidx_d != 2'd3);
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         qcnt_q     <= '0;
         qidx_q     <= '0;
         bcnt_q     <= '0;
         shreg_q    <= '0;
         addr_q     <= '0;
         last_q     <= 1'b0;
         ack_q      <= 1'b0;
         nack_q     <= 1'b0;
         scl_oe_q   <= 1'b0;
         sda_oe_q   <= 1'b0;
         tx_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         qcnt_q     <= qcnt_d;
         qidx_q     <= qidx_d;
         bcnt_q     <= bcnt_d;
         shreg_q    <= shreg_d;
         addr_q     <= addr_d;
         last_q     <= last_d;
         ack_q      <= ack_d;
         nack_q     <= nack_d;
         scl_oe_q   <= scl_oe_d;
         sda_oe_q   <= sda_oe_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx_ready = tx_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign nack     = nack_q;
   assign scl_oe   = scl_oe_q;
   assign sda_oe   = sda_oe_q;

endmodule
